// File: rtl/song_sequencer_pkg.sv
// Shared note-word layout, field widths and sequencer state encodings for the
// song ROM player and its Sound interface.
package song_sequencer_pkg;

  localparam int OCTAVE_BITS    = 3;
  localparam int NOTE_BITS      = 4;
  localparam int LENGTH_BITS    = 3;
  localparam int FULL_NOTE_BITS = 24;
  localparam int WORD_BITS      = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS;

  localparam logic [NOTE_BITS-1:0]   NOTE_NULL = 4'd15;
  localparam logic [LENGTH_BITS-1:0] LEN_END   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_PLAY   = 3'd3,
    ST_GAP    = 3'd4,
    ST_PAUSED = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [OCTAVE_BITS-1:0] octave;
    logic [NOTE_BITS-1:0]   note;
    logic [LENGTH_BITS-1:0] length;
  } note_word_t;

  function automatic logic is_end_marker(input note_word_t w);
    return w.length == LEN_END;
  endfunction

  // Rests are played like any other note; Sound keeps them silent.
  function automatic logic is_rest(input note_word_t w);
    return w.note == NOTE_NULL;
  endfunction

endpackage

// File: rtl/song_sequencer_gap_timer.sv
// Articulation-gap timer: i_start arms a count of GAP_CYCLES cycles and
// o_expire pulses for one cycle once the last count has been reached.
module song_sequencer_gap_timer
  import song_sequencer_pkg::*;
#(
  parameter int GAP_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CNT_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= 1'b0;
      if (i_clear) begin
        r_cnt <= '0;
        r_run <= 1'b0;
      end else if (i_start) begin
        r_cnt <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        // Expire is registered, so the GAP state lasts GAP_CYCLES+1 cycles.
        if (r_cnt == LAST) begin
          r_run    <= 1'b0;
          r_expire <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_expire = r_expire;

endmodule

// File: rtl/song_sequencer.sv
// Song ROM player: fetches packed note words, drives Sound with snd_en until
// the note completes, inserts an articulation gap and advances to the next word.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int GAP_CYCLES = 2_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic [ADDR_BITS-1:0]      song_base,
  input  logic [FULL_NOTE_BITS-1:0] tempo,
  output logic [ADDR_BITS-1:0]      rom_addr,
  input  logic [WORD_BITS-1:0]      rom_data,
  output logic                      snd_en,
  output logic [OCTAVE_BITS-1:0]    snd_octave,
  output logic [NOTE_BITS-1:0]      snd_note,
  output logic [LENGTH_BITS-1:0]    snd_length,
  output logic [FULL_NOTE_BITS-1:0] snd_full_note,
  input  logic                      snd_over,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_BITS-1:0]      note_index
);

  localparam bit GAP_EN = (GAP_CYCLES > 0);

  seq_state_t r_state;
  seq_state_t w_next;
  note_word_t w_word;

  logic w_restart;
  logic w_advance;
  logic w_load_note;
  logic w_snd_off;
  logic w_done;
  logic w_gap_start;
  logic w_gap_clear;
  logic w_gap_expire;

  logic                      r_armed;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_snd_en;
  logic [ADDR_BITS-1:0]      r_addr;
  logic [ADDR_BITS-1:0]      r_idx;
  logic [OCTAVE_BITS-1:0]    r_octave;
  logic [NOTE_BITS-1:0]      r_note;
  logic [LENGTH_BITS-1:0]    r_length;
  logic [FULL_NOTE_BITS-1:0] r_full_note;

  assign w_word = note_word_t'(rom_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_restart   = 1'b0;
    w_advance   = 1'b0;
    w_load_note = 1'b0;
    w_snd_off   = 1'b0;
    w_done      = 1'b0;
    w_gap_start = 1'b0;
    w_gap_clear = 1'b0;
    if (stop) begin
      w_next      = ST_IDLE;
      w_snd_off   = 1'b1;
      w_gap_clear = 1'b1;
    end else if (start) begin
      w_next      = ST_FETCH;
      w_restart   = 1'b1;
      w_snd_off   = 1'b1;
      w_gap_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_IDLE;
        ST_FETCH: w_next = ST_LOAD;
        ST_LOAD: begin
          if (is_end_marker(w_word)) begin
            w_next = ST_IDLE;
            w_done = 1'b1;
          end else begin
            w_next      = ST_PLAY;
            w_load_note = 1'b1;
          end
        end
        ST_PLAY: begin
          // Completion outranks pause so a finished note is never replayed.
          if (r_armed && snd_over) begin
            w_snd_off = 1'b1;
            w_advance = 1'b1;
            if (GAP_EN) begin
              w_next      = ST_GAP;
              w_gap_start = 1'b1;
            end else begin
              w_next = ST_FETCH;
            end
          end else if (pause) begin
            w_next    = ST_PAUSED;
            w_snd_off = 1'b1;
          end
        end
        ST_GAP: begin
          if (pause) begin
            w_next      = ST_PAUSED;
            w_gap_clear = 1'b1;
          end else if (w_gap_expire) begin
            w_next = ST_FETCH;
          end
        end
        ST_PAUSED: begin
          if (!pause) w_next = ST_FETCH;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_armed     <= 1'b0;
      r_snd_en    <= 1'b0;
      r_addr      <= '0;
      r_idx       <= '0;
      r_octave    <= '0;
      r_note      <= '0;
      r_length    <= '0;
      r_full_note <= '0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= w_done;
      if (w_restart) begin
        r_addr <= song_base;
        r_idx  <= '0;
      end else if (w_advance) begin
        r_addr <= r_addr + ADDR_BITS'(1);
        r_idx  <= r_idx + ADDR_BITS'(1);
      end
      if (w_load_note) begin
        r_snd_en    <= 1'b1;
        r_octave    <= w_word.octave;
        r_note      <= w_word.note;
        r_length    <= w_word.length;
        r_full_note <= tempo;
      end else if (w_snd_off) begin
        r_snd_en <= 1'b0;
      end
      // snd_over is still high from the previous note until Sound restarts.
      if (w_load_note)                          r_armed <= 1'b0;
      else if (r_state == ST_PLAY && !snd_over) r_armed <= 1'b1;
    end
  end

  song_sequencer_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_gap_start),
    .i_clear  (w_gap_clear),
    .o_expire (w_gap_expire)
  );

  assign rom_addr      = r_addr;
  assign note_index    = r_idx;
  assign snd_en        = r_snd_en;
  assign snd_octave    = r_octave;
  assign snd_note      = r_note;
  assign snd_length    = r_length;
  assign snd_full_note = r_full_note;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: ROM and Sound stand-ins, a note monitor, table-driven
// songs, hand-written pause/stop/reset sequences and randomized songs.
module tb_song_sequencer;
  import song_sequencer_pkg::*;

  localparam int AB    = 8;
  localparam int GAP   = 4;
  localparam int STALE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic pause = 1'b0;
  logic [AB-1:0] song_base = '0;
  logic [FULL_NOTE_BITS-1:0] tempo = '0;
  logic [AB-1:0] rom_addr;
  logic [AB-1:0] note_index;
  logic [WORD_BITS-1:0] rom_data;
  logic snd_en;
  logic snd_over;
  logic busy;
  logic done;
  logic [OCTAVE_BITS-1:0] snd_octave;
  logic [NOTE_BITS-1:0] snd_note;
  logic [LENGTH_BITS-1:0] snd_length;
  logic [FULL_NOTE_BITS-1:0] snd_full_note;

  logic [WORD_BITS-1:0] rom [256];
  int cyc = 0;
  int s_cnt = 0;
  int n_tests = 0;
  int n_fail = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic mon_prev = 1'b0;
  int rise_q[$];
  int fall_q[$];
  logic [WORD_BITS-1:0] word_q[$];
  logic [FULL_NOTE_BITS-1:0] tempo_q[$];

  typedef struct {
    logic [AB-1:0] base;
    int            n;
    logic [AB-1:0] exp_idx;
    logic [AB-1:0] exp_addr;
  } song_vec_t;

  song_sequencer #(.ADDR_BITS(AB), .GAP_CYCLES(GAP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .pause         (pause),
    .song_base     (song_base),
    .tempo         (tempo),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .snd_en        (snd_en),
    .snd_octave    (snd_octave),
    .snd_note      (snd_note),
    .snd_length    (snd_length),
    .snd_full_note (snd_full_note),
    .snd_over      (snd_over),
    .busy          (busy),
    .done          (done),
    .note_index    (note_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Sound stand-in: stale-high for STALE cycles, low for length+1 cycles, then high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt    <= 0;
      snd_over <= 1'b1;
    end else if (!snd_en) begin
      s_cnt    <= 0;
      snd_over <= 1'b1;
    end else begin
      s_cnt    <= s_cnt + 1;
      snd_over <= !(s_cnt >= STALE && s_cnt < STALE + int'(snd_length) + 1);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (snd_en === 1'b1 && mon_prev !== 1'b1) begin
      rise_q.push_back(cyc);
      word_q.push_back({snd_octave, snd_note, snd_length});
      tempo_q.push_back(snd_full_note);
    end
    if (snd_en !== 1'b1 && mon_prev === 1'b1) fall_q.push_back(cyc);
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    mon_prev = snd_en;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    rise_q.delete();
    fall_q.delete();
    word_q.delete();
    tempo_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [AB-1:0] base);
    @(negedge clk);
    song_base = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    chk("start_addr", 64'(rom_addr), 64'(base));
    chk("start_index", 64'(note_index), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_rises(input int want);
    int k = 0;
    while (rise_q.size() < want && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rise_wait", 64'(rise_q.size()), 64'(want));
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Expected song: words from base onward until the end marker, address wrapping mod 256.
  task automatic verify_song(input logic [AB-1:0] base, input bit timing);
    logic [WORD_BITS-1:0] exp_q[$];
    logic [AB-1:0] a;
    int n;
    a = base;
    while (rom[a][LENGTH_BITS-1:0] != LEN_END && exp_q.size() < 256) begin
      exp_q.push_back(rom[a]);
      a = a + 8'd1;
    end
    n = exp_q.size();
    chk("note_count", 64'(rise_q.size()), 64'(n));
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("note_index", 64'(note_index), 64'(n % 256));
    chk("end_addr", 64'(rom_addr), 64'(a));
    for (int i = 0; i < n && i < rise_q.size(); i++) begin
      chk("note_word", 64'(word_q[i]), 64'(exp_q[i]));
      chk("full_note", 64'(tempo_q[i]), 64'(tempo));
      if (i < fall_q.size())
        chk("note_len", 64'(fall_q[i] - rise_q[i]), 64'(int'(exp_q[i][LENGTH_BITS-1:0]) + STALE + 3));
      if (timing) begin
        if (i == 0) chk("first_lat", 64'(rise_q[0] - start_cyc), 64'd2);
        else if (i - 1 < fall_q.size()) chk("gap_len", 64'(rise_q[i] - fall_q[i-1]), 64'(GAP + 3));
      end
    end
    if (timing && n == 0) chk("done_lat", 64'(done_cyc - start_cyc), 64'd2);
    if (timing && n > 0 && fall_q.size() >= n)
      chk("done_lat", 64'(done_cyc - fall_q[n-1]), 64'(GAP + 3));
  endtask

  task automatic run_song(input logic [AB-1:0] base);
    clear_mon();
    pulse_start(base);
    wait_idle("song");
    verify_song(base, 1'b1);
  endtask

  song_vec_t vecs[5];
  int hi;
  int m_cyc;
  int k;
  logic [AB-1:0] rb;
  int rn;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {7'd0, LEN_END};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_index", 64'(note_index), 64'd0);
    chk("rst_snd_en", 64'(snd_en), 64'd0);
    chk("rst_fields", 64'({snd_octave, snd_note, snd_length, snd_full_note}), 64'd0);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    vecs[0] = '{8'd0,   2, 8'd2, 8'd2};
    vecs[1] = '{8'd16,  0, 8'd0, 8'd16};
    vecs[2] = '{8'd255, 1, 8'd1, 8'd0};
    vecs[3] = '{8'd254, 3, 8'd3, 8'd1};
    vecs[4] = '{8'd100, 4, 8'd4, 8'd104};
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        rom[8'(vecs[v].base + 8'(i))] = {3'(i + 1), 4'(i * 3), 3'(i % 7)};
      rom[8'(vecs[v].base + 8'(vecs[v].n))] = {3'd2, 4'd5, LEN_END};
      tempo = 24'(1000 + v);
      run_song(vecs[v].base);
      chk("tbl_index", 64'(note_index), 64'(vecs[v].exp_idx));
      chk("tbl_addr", 64'(rom_addr), 64'(vecs[v].exp_addr));
    end

    // Two-note song at 40: {4,0,2}, {4,2,2}, end.
    rom[40] = {3'd4, 4'd0, 3'd2};
    rom[41] = {3'd4, 4'd2, 3'd2};
    rom[42] = {3'd0, 4'd0, LEN_END};
    tempo = 24'h000123;
    run_song(8'd40);

    // Pause mid-note: note replays from the same address.
    clear_mon();
    pulse_start(8'd40);
    wait_rises(1);
    repeat (2) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    chk("pause_snd_en", 64'(snd_en), 64'd0);
    chk("pause_busy", 64'(busy), 64'd1);
    chk("pause_addr", 64'(rom_addr), 64'd40);
    hi = 0;
    repeat (49) begin
      @(negedge clk);
      if (snd_en !== 1'b0) hi++;
    end
    chk("pause_hold", 64'(hi), 64'd0);
    pause = 1'b0;
    wait_idle("pause");
    chk("replay_count", 64'(rise_q.size()), 64'd3);
    if (rise_q.size() >= 3 && fall_q.size() >= 2) begin
      chk("replay_word0", 64'(word_q[1]), 64'(rom[40]));
      chk("replay_word1", 64'(word_q[2]), 64'(rom[41]));
      chk("replay_len", 64'(fall_q[1] - rise_q[1]), 64'(2 + STALE + 3));
    end
    chk("pause_done", 64'(done_cnt), 64'd1);
    chk("pause_index", 64'(note_index), 64'd2);

    // Pause arriving on the completion edge: completion advances first.
    clear_mon();
    pulse_start(8'd40);
    wait_rises(1);
    m_cyc = (rise_q.size() > 0 ? rise_q[0] : cyc) + STALE + 3 + 2;
    k = 0;
    while (cyc < m_cyc - 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    pause = 1'b1;
    @(negedge clk);
    chk("cp_snd_en", 64'(snd_en), 64'd0);
    chk("cp_addr", 64'(rom_addr), 64'd41);
    chk("cp_index", 64'(note_index), 64'd1);
    repeat (10) @(negedge clk);
    chk("cp_held_busy", 64'(busy), 64'd1);
    chk("cp_held_rises", 64'(rise_q.size()), 64'd1);
    pause = 1'b0;
    wait_idle("cp");
    chk("cp_rises", 64'(rise_q.size()), 64'd2);
    if (rise_q.size() >= 2) chk("cp_word1", 64'(word_q[1]), 64'(rom[41]));
    chk("cp_done", 64'(done_cnt), 64'd1);

    // Stop during GAP, then restart from song_base.
    clear_mon();
    pulse_start(8'd40);
    k = 0;
    while (fall_q.size() < 1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_snd_en", 64'(snd_en), 64'd0);
    repeat (10) @(negedge clk);
    chk("stop_no_done", 64'(done_cnt), 64'd0);
    chk("stop_rises", 64'(rise_q.size()), 64'd1);
    run_song(8'd40);

    // start and stop together while busy: stop wins.
    clear_mon();
    pulse_start(8'd40);
    wait_rises(1);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", 64'(busy), 64'd0);
    chk("ss_snd_en", 64'(snd_en), 64'd0);
    repeat (8) @(negedge clk);
    chk("ss_no_done", 64'(done_cnt), 64'd0);
    chk("ss_snd_en_later", 64'(snd_en), 64'd0);

    // start while busy restarts the song.
    clear_mon();
    pulse_start(8'd40);
    wait_rises(2);
    pulse_start(8'd40);
    chk("rs_snd_en", 64'(snd_en), 64'd0);
    @(negedge clk);
    clear_mon();
    wait_idle("restart");
    verify_song(8'd40, 1'b0);

    // Asynchronous reset mid-PLAY.
    clear_mon();
    pulse_start(8'd40);
    wait_rises(1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_snd_en", 64'(snd_en), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_addr_idx", 64'({rom_addr, note_index}), 64'd0);
    chk("arst_fields", 64'({snd_octave, snd_note, snd_length, snd_full_note}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized songs against the reference model.
    for (int r = 0; r < 6; r++) begin
      rb = 8'($urandom_range(0, 255));
      rn = int'($urandom_range(1, 5));
      for (int i = 0; i < rn; i++)
        rom[8'(rb + 8'(i))] = {3'($urandom), 4'($urandom), 3'($urandom_range(0, 6))};
      rom[8'(rb + 8'(rn))] = {3'($urandom), 4'($urandom), LEN_END};
      tempo = 24'($urandom);
      run_song(rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
